// File: rtl/pc_gen_stage_pkg.sv
// Shared constants for the pre-fetch PC generator: default vectors, fetch exception codes
// and the stage state encoding.
package pc_gen_stage_pkg;

    localparam logic [31:0] ResetPcDef     = 32'hBFC0_0000;
    localparam logic [31:0] GeneralExPcDef = 32'hBFC0_0380;
    localparam logic [31:0] RefillExPcDef  = 32'hBFC0_0200;

    localparam logic [4:0] ExcAdel = 5'h04;
    localparam logic [4:0] ExcTlbl = 5'h02;
    localparam logic [4:0] ExcNone = 5'h1F;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StFwait = 1'b1
    } ps_state_e;

    // Byte-offset mask of one fetch group (group size minus one).
    function automatic logic [31:0] group_mask(input int unsigned fetch_w);
        return 32'(fetch_w * 4 - 1);
    endfunction

endpackage

// File: rtl/pc_gen_redirect_q.sv
// Pending branch/BPU redirect held across IF stalls; a resolved branch always wins over a
// held prediction, a prediction may only replace another prediction.
module pc_gen_redirect_q (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        bpu_valid_i,
    input  logic [31:0] bpu_target_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        bdd_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic        bdd_q, bdd_d;
    logic        from_bpu_q, from_bpu_d;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        bdd_d      = bdd_q;
        from_bpu_d = from_bpu_q;
        if (clear_i) begin
            valid_d    = 1'b0;
            bdd_d      = 1'b0;
            from_bpu_d = 1'b0;
        end else if (br_taken_i) begin
            valid_d    = 1'b1;
            pc_d       = br_target_i;
            bdd_d      = 1'b1;
            from_bpu_d = 1'b0;
        end else if (bpu_valid_i && (!valid_q || from_bpu_q)) begin
            valid_d    = 1'b1;
            pc_d       = bpu_target_i;
            bdd_d      = 1'b0;
            from_bpu_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_q       <= 32'h0;
            bdd_q      <= 1'b0;
            from_bpu_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            bdd_q      <= bdd_d;
            from_bpu_q <= from_bpu_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign bdd_o   = bdd_q;

endmodule

// File: rtl/pc_gen_stage.sv
// Pre-fetch PC generator: picks the next fetch-group PC, translates it, flags fetch
// exceptions and drives the ICache request for FETCH_W-wide aligned groups.
module pc_gen_stage
    import pc_gen_stage_pkg::*;
#(
    parameter int unsigned FETCH_W       = 1,
    parameter bit          TLB_EN        = 1'b1,
    parameter logic [31:0] RESET_PC      = ResetPcDef,
    parameter logic [31:0] GENERAL_EX_PC = GeneralExPcDef,
    parameter logic [31:0] REFILL_EX_PC  = RefillExPcDef
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fs_allowin,
    input  logic               icache_busy,
    input  logic               eret,
    input  logic [31:0]        epc,
    input  logic               flush,
    input  logic               flush_refill,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               bpu_valid,
    input  logic [31:0]        bpu_target,
    input  logic               itlb_hit,
    input  logic               itlb_v,
    input  logic [19:0]        itlb_pfn,
    output logic               ps_to_fs_valid,
    output logic [31:0]        ps_pc,
    output logic [FETCH_W-1:0] ps_lane_mask,
    output logic               ps_bdd,
    output logic               ps_ex,
    output logic [4:0]         ps_excode,
    output logic               ps_refill,
    output logic               icache_req,
    output logic [31:0]        icache_paddr
);

    localparam logic [31:0] GbMask   = group_mask(FETCH_W);
    localparam logic [31:0] GbSize   = GbMask + 32'd1;
    localparam logic [31:0] LaneMask = 32'(FETCH_W - 1);

    ps_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] seq_pc;
    logic        fire, kill, fwait_exit;
    logic        pend_valid, pend_bdd;
    logic [31:0] pend_pc;

    assign kill       = eret | flush;
    assign fire       = (state_q == StRun) & ~icache_busy & fs_allowin;
    assign fwait_exit = (state_q == StFwait) & ~icache_busy;
    assign seq_pc     = (pc_q & ~GbMask) + GbSize;

    // Any consumption (fire) or kill empties the pending slot; otherwise it captures redirects.
    pc_gen_redirect_q u_redirect_q (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (kill | fire),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .bpu_valid_i  (bpu_valid),
        .bpu_target_i (bpu_target),
        .valid_o      (pend_valid),
        .pc_o         (pend_pc),
        .bdd_o        (pend_bdd)
    );

    always_comb begin
        pc_d = pc_q;
        if (eret) begin
            pc_d = epc;
        end else if (flush) begin
            pc_d = flush_refill ? REFILL_EX_PC : GENERAL_EX_PC;
        end else if (fire) begin
            if (br_taken) begin
                pc_d = br_target;
            end else if (bpu_valid) begin
                pc_d = bpu_target;
            end else if (pend_valid) begin
                pc_d = pend_pc;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = icache_busy ? StFwait : StRun;
        end else if (fwait_exit) begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= StRun;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // Translation and fetch exception decode; kseg0/kseg1 are always direct-mapped.
    logic        adel, mapped, tlb_refill, tlb_inv;
    logic [31:0] paddr_raw;

    assign adel       = |pc_q[1:0];
    assign mapped     = TLB_EN && (pc_q[31:30] != 2'b10);
    assign tlb_refill = ~adel & mapped & ~itlb_hit;
    assign tlb_inv    = ~adel & mapped & itlb_hit & ~itlb_v;

    always_comb begin
        ps_excode = ExcNone;
        if (adel) begin
            ps_excode = ExcAdel;
        end else if (tlb_refill || tlb_inv) begin
            ps_excode = ExcTlbl;
        end
    end

    assign ps_ex     = adel | tlb_refill | tlb_inv;
    assign ps_refill = tlb_refill;
    assign paddr_raw = mapped ? {itlb_pfn, pc_q[11:0]} : {3'b000, pc_q[28:0]};

    // First valid lane is the word index of pc inside its group.
    logic [31:0] lane_first;
    assign lane_first = {2'b00, pc_q[31:2]} & LaneMask;

    always_comb begin
        ps_lane_mask = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            ps_lane_mask[i] = (32'(i) >= lane_first);
        end
    end

    assign ps_to_fs_valid = fire;
    assign ps_pc          = pc_q;
    assign ps_bdd         = pend_bdd | br_taken;
    assign icache_req     = ((state_q == StRun) & ~ps_ex & fs_allowin) | fwait_exit;
    assign icache_paddr   = paddr_raw & ~GbMask;

endmodule

// File: tb/tb_pc_gen_stage.sv
// Scripted bench for pc_gen_stage (FETCH_W=4, TLB on): fired group PCs are scoreboarded,
// everything else is compared in place.
module tb_pc_gen_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin, icache_busy;
    logic        eret, flush, flush_refill, br_taken, bpu_valid;
    logic [31:0] epc, br_target, bpu_target;
    logic        itlb_hit, itlb_v;
    logic [19:0] itlb_pfn;
    logic        ps_to_fs_valid, ps_bdd, ps_ex, ps_refill, icache_req;
    logic [31:0] ps_pc, icache_paddr;
    logic [3:0]  ps_lane_mask;
    logic [4:0]  ps_excode;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    pc_gen_stage #(
        .FETCH_W (4),
        .TLB_EN  (1'b1)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .fs_allowin     (fs_allowin),
        .icache_busy    (icache_busy),
        .eret           (eret),
        .epc            (epc),
        .flush          (flush),
        .flush_refill   (flush_refill),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .bpu_valid      (bpu_valid),
        .bpu_target     (bpu_target),
        .itlb_hit       (itlb_hit),
        .itlb_v         (itlb_v),
        .itlb_pfn       (itlb_pfn),
        .ps_to_fs_valid (ps_to_fs_valid),
        .ps_pc          (ps_pc),
        .ps_lane_mask   (ps_lane_mask),
        .ps_bdd         (ps_bdd),
        .ps_ex          (ps_ex),
        .ps_excode      (ps_excode),
        .ps_refill      (ps_refill),
        .icache_req     (icache_req),
        .icache_paddr   (icache_paddr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every fired group must match the next expected PC.
    always @(negedge clk) begin
        if (!reset && ps_to_fs_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra_fire", 32'(ps_to_fs_valid), 32'd0);
            end else begin
                exp_pc = exp_q.pop_front();
                check_eq("sb_fire_pc", ps_pc, exp_pc);
            end
        end
    end

    initial begin
        reset = 1'b1; fs_allowin = 1'b1; icache_busy = 1'b0;
        eret = 1'b0; flush = 1'b0; flush_refill = 1'b0; br_taken = 1'b0; bpu_valid = 1'b0;
        epc = 32'h0; br_target = 32'h0; bpu_target = 32'h0;
        itlb_hit = 1'b1; itlb_v = 1'b1; itlb_pfn = 20'h0;
        cyc();
        cyc();

        // Reset state and sequential groups
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0010);
        exp_q.push_back(32'hBFC0_0020);
        reset = 1'b0;
        #1;
        check_eq("rst_pc", ps_pc, 32'hBFC0_0000);
        check_eq("rst_ex", 32'(ps_ex), 32'd0);
        check_eq("rst_excode", 32'(ps_excode), 32'h1F);
        check_eq("rst_mask", 32'(ps_lane_mask), 32'hF);
        check_eq("rst_bdd", 32'(ps_bdd), 32'd0);
        check_eq("rst_req", 32'(icache_req), 32'd1);
        check_eq("rst_paddr", icache_paddr, 32'h1FC0_0000);
        cyc();
        check_eq("seq_pc1", ps_pc, 32'hBFC0_0010);
        cyc();
        check_eq("seq_pc2", ps_pc, 32'hBFC0_0020);
        cyc();
        fs_allowin = 1'b0;

        // BPU redirect on fire
        exp_q.push_back(32'hBFC0_0030);
        fs_allowin = 1'b1; bpu_valid = 1'b1; bpu_target = 32'h8000_0008;
        cyc();
        bpu_valid = 1'b0; fs_allowin = 1'b0;
        #1;
        check_eq("bpu_pc", ps_pc, 32'h8000_0008);
        check_eq("bpu_mask", 32'(ps_lane_mask), 32'hC);
        check_eq("bpu_paddr", icache_paddr, 32'h0000_0000);
        check_eq("bpu_ex", 32'(ps_ex), 32'd0);

        // Branch pulsed during a 3-cycle stall
        fs_allowin = 1'b1; icache_busy = 1'b1; br_taken = 1'b1; br_target = 32'h8000_1000;
        cyc();
        br_taken = 1'b0;
        #1;
        check_eq("br_pend_bdd", 32'(ps_bdd), 32'd1);
        check_eq("br_stall_pc", ps_pc, 32'h8000_0008);
        cyc();
        cyc();
        exp_q.push_back(32'h8000_0008);
        icache_busy = 1'b0;
        #1;
        check_eq("br_fire_bdd", 32'(ps_bdd), 32'd1);
        cyc();
        fs_allowin = 1'b0;
        #1;
        check_eq("br_pc", ps_pc, 32'h8000_1000);
        check_eq("br_consumed_bdd", 32'(ps_bdd), 32'd0);

        // Refill flush while busy -> FWAIT
        fs_allowin = 1'b1; icache_busy = 1'b1; flush = 1'b1; flush_refill = 1'b1;
        cyc();
        flush = 1'b0; flush_refill = 1'b0;
        #1;
        check_eq("fl_pc", ps_pc, 32'hBFC0_0200);
        check_eq("fl_req_wait", 32'(icache_req), 32'd0);
        check_eq("fl_fire_wait", 32'(ps_to_fs_valid), 32'd0);
        cyc();
        check_eq("fl_req_wait2", 32'(icache_req), 32'd0);
        exp_q.push_back(32'hBFC0_0200);
        icache_busy = 1'b0;
        #1;
        check_eq("fl_req_exit", 32'(icache_req), 32'd1);
        check_eq("fl_fire_exit", 32'(ps_to_fs_valid), 32'd0);
        cyc();
        check_eq("fl_pc_run", ps_pc, 32'hBFC0_0200);
        cyc();
        fs_allowin = 1'b0;

        // Fetch exceptions and translation
        exp_q.push_back(32'hBFC0_0210);
        fs_allowin = 1'b1; bpu_valid = 1'b1; bpu_target = 32'h0040_0002;
        cyc();
        bpu_valid = 1'b0; icache_busy = 1'b1;
        #1;
        check_eq("adel_ex", 32'(ps_ex), 32'd1);
        check_eq("adel_code", 32'(ps_excode), 32'h04);
        check_eq("adel_req", 32'(icache_req), 32'd0);
        itlb_hit = 1'b0;
        #1;
        check_eq("adel_prio_code", 32'(ps_excode), 32'h04);
        check_eq("adel_prio_refill", 32'(ps_refill), 32'd0);
        exp_q.push_back(32'h0040_0002);
        icache_busy = 1'b0; bpu_valid = 1'b1; bpu_target = 32'h0040_0000; itlb_hit = 1'b1;
        cyc();
        bpu_valid = 1'b0; icache_busy = 1'b1; itlb_hit = 1'b0;
        #1;
        check_eq("miss_ex", 32'(ps_ex), 32'd1);
        check_eq("miss_code", 32'(ps_excode), 32'h02);
        check_eq("miss_refill", 32'(ps_refill), 32'd1);
        check_eq("miss_req", 32'(icache_req), 32'd0);
        itlb_hit = 1'b1; itlb_v = 1'b0;
        #1;
        check_eq("inv_code", 32'(ps_excode), 32'h02);
        check_eq("inv_refill", 32'(ps_refill), 32'd0);
        itlb_v = 1'b1; itlb_pfn = 20'h12345;
        #1;
        check_eq("hit_ex", 32'(ps_ex), 32'd0);
        check_eq("hit_code", 32'(ps_excode), 32'h1F);
        check_eq("hit_req", 32'(icache_req), 32'd1);
        check_eq("hit_paddr", icache_paddr, 32'h1234_5000);

        // eret + flush + branch with a pending entry
        br_taken = 1'b1; br_target = 32'h8000_2000;
        cyc();
        br_taken = 1'b0;
        #1;
        check_eq("er_pend_bdd", 32'(ps_bdd), 32'd1);
        exp_q.push_back(32'h0040_0000);
        icache_busy = 1'b0; eret = 1'b1; flush = 1'b1; epc = 32'h8000_0100;
        br_taken = 1'b1; br_target = 32'h8000_3000;
        cyc();
        eret = 1'b0; flush = 1'b0; br_taken = 1'b0; fs_allowin = 1'b0;
        #1;
        check_eq("er_pc", ps_pc, 32'h8000_0100);
        check_eq("er_bdd", 32'(ps_bdd), 32'd0);
        exp_q.push_back(32'h8000_0100);
        fs_allowin = 1'b1;
        cyc();
        fs_allowin = 1'b0;
        #1;
        check_eq("er_pend_gone", ps_pc, 32'h8000_0110);

        // Branch entry is not overwritten by BPU; BPU replaces BPU
        fs_allowin = 1'b1; icache_busy = 1'b1; br_taken = 1'b1; br_target = 32'h8000_5000;
        cyc();
        br_taken = 1'b0; bpu_valid = 1'b1; bpu_target = 32'h8000_6000;
        cyc();
        bpu_valid = 1'b0;
        #1;
        check_eq("prio_bdd", 32'(ps_bdd), 32'd1);
        exp_q.push_back(32'h8000_0110);
        icache_busy = 1'b0;
        cyc();
        check_eq("prio_br_kept", ps_pc, 32'h8000_5000);
        icache_busy = 1'b1; bpu_valid = 1'b1; bpu_target = 32'h8000_7000;
        cyc();
        bpu_target = 32'h8000_8000;
        cyc();
        bpu_valid = 1'b0;
        #1;
        check_eq("bpu_pend_bdd", 32'(ps_bdd), 32'd0);
        exp_q.push_back(32'h8000_5000);
        icache_busy = 1'b0;
        cyc();
        fs_allowin = 1'b0;
        #1;
        check_eq("bpu_replace", ps_pc, 32'h8000_8000);

        // Reset mid-stall drops the pending branch
        fs_allowin = 1'b1; icache_busy = 1'b1; br_taken = 1'b1; br_target = 32'h8000_4000;
        cyc();
        br_taken = 1'b0; reset = 1'b1;
        cyc();
        exp_q.push_back(32'hBFC0_0000);
        reset = 1'b0; icache_busy = 1'b0;
        #1;
        check_eq("rst2_pc", ps_pc, 32'hBFC0_0000);
        check_eq("rst2_bdd", 32'(ps_bdd), 32'd0);
        cyc();
        fs_allowin = 1'b0;
        #1;
        check_eq("rst2_seq", ps_pc, 32'hBFC0_0010);

        // General flush into FWAIT, then reset returns to RUN
        icache_busy = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        check_eq("gen_vec_pc", ps_pc, 32'hBFC0_0380);
        reset = 1'b1;
        cyc();
        reset = 1'b0; fs_allowin = 1'b1;
        #1;
        check_eq("rst_fwait_req", 32'(icache_req), 32'd1);
        cyc();
        fs_allowin = 1'b0;
        icache_busy = 1'b0;
        #1;

        check_eq("sb_left", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_stage.md
# pc_gen_stage

Parametrised next-generation pre-fetch PC generator. Sits ahead of the IF stage. It selects the next fetch-group PC from these sources: eret, exception flush, branch redirect, branch-predictor target, or sequential. It translates the PC (direct-mapped kseg0/kseg1 or via ITLB lookup), flags fetch exceptions, and drives the ICache request. Unlike the previous single-instruction generator, it fetches FETCH_W-wide aligned groups and emits a lane mask. It also retains a branch/BPU redirect that arrives while the stage is stalled, so that redirect is not lost.

## Interface
Parameters:
- FETCH_W, 1: instructions per fetch group; legal values 1, 2, 4.
- TLB_EN, 1: 1 means kuseg/kseg2/kseg3 are translated through the ITLB inputs; 0 means every address is direct-mapped (pc & 32'h1FFF_FFFF).
- RESET_PC, 32'hBFC0_0000: PC after reset.
- GENERAL_EX_PC, 32'hBFC0_0380: general exception vector.
- REFILL_EX_PC, 32'hBFC0_0200: TLB refill vector.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fs_allowin  in  1  IF stage can accept a group.
- icache_busy  in  1  ICache cannot accept a request.
- eret  in  1  eret committed; redirect to epc.
- epc  in  32  CP0 EPC.
- flush  in  1  exception flush.
- flush_refill  in  1  qualifies flush; selects REFILL_EX_PC.
- br_taken  in  1  resolved branch redirect.
- br_target  in  32  branch target.
- bpu_valid  in  1  predictor redirect.
- bpu_target  in  32  predicted target.
- itlb_hit  in  1  ITLB match for the current pc.
- itlb_v  in  1  valid bit of the matching entry.
- itlb_pfn  in  20  PFN of the matching entry.
- ps_to_fs_valid  out  1  group handed to IF this cycle.
- ps_pc  out  32  current group PC (unaligned within the group allowed).
- ps_lane_mask  out  FETCH_W  valid lanes, from lane pc[LW+1:2] through FETCH_W-1.
- ps_bdd  out  1  group follows a taken branch (pending or live).
- ps_ex  out  1  fetch exception.
- ps_excode  out  5  5'h04 AdEL, 5'h02 TLBL, 5'h1F none.
- ps_refill  out  1  TLBL is a refill (miss), not an invalid-entry fault.
- icache_req  out  1  ICache request valid.
- icache_paddr  out  32  physical address, group-aligned.

## Operation
- LW = log2(FETCH_W); GB = FETCH_W*4.
- Sequential PC = (pc & ~(GB-1)) + GB, computed as 32-bit wrap-around.
- fire = state==RUN & ~icache_busy & fs_allowin. ps_to_fs_valid = fire.
- Next-PC priority:
  1. eret → epc.
  2. flush → REFILL_EX_PC if flush_refill, else GENERAL_EX_PC.
  3. br_taken → br_target.
  4. bpu_valid → bpu_target.
  5. pend_valid → pend_pc.
  6. Otherwise the sequential PC.
- eret or flush: pc is loaded in the same cycle regardless of stall. pend_valid is cleared. If eret and flush are both asserted, eret wins.
- br_taken or bpu_valid without fire: the target is latched into the pending register.
  - br_taken overwrites any pending entry.
  - bpu_valid writes only when pend_valid=0 or the held entry came from the BPU.
  - pend_bdd is set when the source is br_taken.
- On fire, the pending entry (or a live br/bpu input) is consumed and pend_valid is cleared.
- States:
  - RUN.
  - FWAIT: entered on eret/flush while icache_busy. Held until ~icache_busy, then returns to RUN.
  - eret/flush with ~icache_busy stays in RUN.
  - No fire occurs in FWAIT.
- Exceptions:
  - AdEL if pc[1:0]!=0.
  - Otherwise, when TLB_EN and pc[31:30]!=2'b10: refill if ~itlb_hit; invalid if itlb_hit & ~itlb_v.
  - AdEL has priority over TLB faults.
- Physical address: {itlb_pfn, pc[11:0]} when mapped; otherwise {3'b0, pc[28:0]}. Low log2(GB) bits are zeroed.
- icache_req = state==RUN & ~ps_ex & fs_allowin, plus a one-shot request in the cycle FWAIT exits.
- Reset values: pc=RESET_PC, state RUN, pend_valid=0, pend_bdd=0. After reset: outputs are combinational from these; ps_ex=0, ps_excode=5'h1F.

## Timing
- Redirect-to-ps_pc latency is 1 cycle when fire or flush/eret. It is stalled-cycles+1 for a pending redirect.
- A redirect present for a single stalled cycle must still appear as ps_pc after the next fire.
- Reset asserted mid-stall or in FWAIT discards the pending entry and returns to RUN next cycle.
- flush in the same cycle as br_taken: the branch is dropped.

## Structure
- Shared package/header: vector constants, excode constants (AdEL, TLBL, NONE), and the FWAIT/RUN state encoding.
- One natural sub-module: pc_gen_redirect_q, the pending redirect register with its source-priority write rules.
- Translation and exception decode stay inline.

## Test plan
- Reset with FETCH_W=4, ~icache_busy, fs_allowin=1 → ps_pc = BFC00000, BFC00010, BFC00020; lane_mask 4'b1111.
- bpu_target=8000_0008, FETCH_W=4, fire → next ps_pc=80000008, lane_mask 4'b1100, icache_paddr=00000000.
- br_taken (target 8000_1000) pulsed 1 cycle while icache_busy held 3 cycles → ps_pc=80001000 on the first fire after busy drops; ps_bdd=1.
- flush+flush_refill while icache_busy → ps_pc=BFC00200 next cycle; no fire until busy drops; one icache_req then.
- pc=0040_0002 → ps_ex=1, excode 04, icache_req=0. pc=0040_0000 with itlb_hit=0 → excode 02, ps_refill=1. With hit & ~v → ps_refill=0.
- eret (epc=8000_0100) and flush together with br_taken → ps_pc=80000100; pending cleared.
